// File: rtl/corr_score_engine.sv
// Window correlation scorer: raster-scans WIN_H x WIN_V pixels from frame and template, sums saturating similarity.
// Optional best-score tracking is compiled in when CORR_SCORE_BEST_TRACK_EN is defined.
module corr_score_engine #(
    parameter int PIX_W   = 10,
    parameter int COORD_W = 13,
    parameter int WIN_H   = 64,
    parameter int WIN_V   = 48,
    parameter int RD_LAT  = 2,
    parameter int SCORE_W = 32
) (
    input  logic               iCLK,
    input  logic               iRST,
    input  logic               iStart,
    input  logic [COORD_W-1:0] iXstart,
    input  logic [COORD_W-1:0] iYstart,
    input  logic [PIX_W-1:0]   iPixSram,
    input  logic [PIX_W-1:0]   iPixSearch,
    output logic [COORD_W-1:0] oX_sram,
    output logic [COORD_W-1:0] oY_sram,
    output logic [COORD_W-1:0] oX_search,
    output logic [COORD_W-1:0] oY_search,
    output logic               oBusy,
    output logic               oDone,
    output logic [SCORE_W-1:0] oScore
`ifdef CORR_SCORE_BEST_TRACK_EN
    ,
    input  logic               iClearBest,
    output logic [SCORE_W-1:0] oBestScore,
    output logic [COORD_W-1:0] oBestX,
    output logic [COORD_W-1:0] oBestY
`endif
);

    localparam int PW = (RD_LAT > 0) ? RD_LAT : 1;
    localparam logic [PW-1:0]      LOW_MASK = {PW{1'b1}} >> 1;
    localparam logic [COORD_W-1:0] X_LAST   = COORD_W'(WIN_H - 1);
    localparam logic [COORD_W-1:0] Y_LAST   = COORD_W'(WIN_V - 1);

    typedef enum logic [1:0] {IDLE, SCAN, DRAIN} state_t;

    function automatic logic [PIX_W-1:0] abs_diff(input logic [PIX_W-1:0] a, input logic [PIX_W-1:0] b);
        logic signed [PIX_W:0] d;
        logic signed [PIX_W:0] m;
        d = $signed({1'b0, a}) - $signed({1'b0, b});
        m = (d < 0) ? -d : d;
        return m[PIX_W-1:0];
    endfunction

    function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] acc, input logic [PIX_W-1:0] t);
        logic [SCORE_W:0] s;
        s = {1'b0, acc} + (SCORE_W + 1)'(t);
        return s[SCORE_W] ? {SCORE_W{1'b1}} : s[SCORE_W-1:0];
    endfunction

    state_t             state_q, state_d;
    logic [COORD_W-1:0] x_q, x_d, y_q, y_d, xs_q, xs_d, ys_q, ys_d;
    logic [PW-1:0]      vld_q, vld_d;
    logic [SCORE_W-1:0] acc_q, acc_d, score_q, score_d;
    logic               done_q, done_d, busy_q, busy_d;
    logic [PIX_W-1:0]   term;
    logic               pipe_out, last;
`ifdef CORR_SCORE_BEST_TRACK_EN
    logic [SCORE_W-1:0] best_q, best_d;
    logic [COORD_W-1:0] bestx_q, bestx_d, besty_q, besty_d;
`endif

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        xs_d    = xs_q;
        ys_d    = ys_q;
        acc_d   = acc_q;
        score_d = score_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        term    = {PIX_W{1'b1}} - abs_diff(iPixSram, iPixSearch);

        vld_d[0] = (state_q == SCAN);
        for (int i = 1; i < PW; i++) vld_d[i] = vld_q[i-1];
        pipe_out = (RD_LAT == 0) ? (state_q == SCAN) : vld_q[PW-1];
        // The final sample leaves the pipe when nothing younger is still in flight.
        last = pipe_out && ((RD_LAT == 0)
               ? (state_q == SCAN && x_q == X_LAST && y_q == Y_LAST)
               : (state_q == DRAIN && (vld_q & LOW_MASK) == '0));

        if (pipe_out) acc_d = sat_add(acc_q, term);

        case (state_q)
            IDLE: begin
                if (iStart && !done_q) begin
                    xs_d    = iXstart;
                    ys_d    = iYstart;
                    x_d     = '0;
                    y_d     = '0;
                    acc_d   = '0;
                    busy_d  = 1'b1;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                if (x_q == X_LAST) begin
                    if (y_q == Y_LAST) begin
                        state_d = DRAIN;
                    end else begin
                        x_d = '0;
                        y_d = y_q + 1'b1;
                    end
                end else begin
                    x_d = x_q + 1'b1;
                end
            end
            default: ;
        endcase

        if (last) begin
            score_d = sat_add(acc_q, term);
            done_d  = 1'b1;
            busy_d  = 1'b0;
            x_d     = '0;
            y_d     = '0;
            state_d = IDLE;
        end

`ifdef CORR_SCORE_BEST_TRACK_EN
        best_d  = best_q;
        bestx_d = bestx_q;
        besty_d = besty_q;
        if (last && score_d > best_q) begin
            best_d  = score_d;
            bestx_d = xs_q;
            besty_d = ys_q;
        end
        if (iClearBest) begin
            best_d  = '0;
            bestx_d = '0;
            besty_d = '0;
        end
`endif
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            xs_q    <= '0;
            ys_q    <= '0;
            vld_q   <= '0;
            acc_q   <= '0;
            score_q <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
`ifdef CORR_SCORE_BEST_TRACK_EN
            best_q  <= '0;
            bestx_q <= '0;
            besty_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            xs_q    <= xs_d;
            ys_q    <= ys_d;
            vld_q   <= vld_d;
            acc_q   <= acc_d;
            score_q <= score_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
`ifdef CORR_SCORE_BEST_TRACK_EN
            best_q  <= best_d;
            bestx_q <= bestx_d;
            besty_q <= besty_d;
`endif
        end
    end

    assign oX_sram   = xs_q + x_q;
    assign oY_sram   = ys_q + y_q;
    assign oX_search = x_q;
    assign oY_search = y_q;
    assign oBusy     = busy_q;
    assign oDone     = done_q;
    assign oScore    = score_q;
`ifdef CORR_SCORE_BEST_TRACK_EN
    assign oBestScore = best_q;
    assign oBestX     = bestx_q;
    assign oBestY     = besty_q;
`endif

endmodule

// File: tb/tb_corr_score_engine.sv
// Bench for corr_score_engine on a 4x2 window with RD_LAT=2; a second 12-bit-score instance exercises saturation.
module tb_corr_score_engine;

    localparam int PIX_W = 10, COORD_W = 13, WIN_H = 4, WIN_V = 2, RD_LAT = 2, SCORE_W = 32;

    logic               clk = 1'b0;
    logic               iRST, iStart;
    logic [COORD_W-1:0] iXstart, iYstart;
    logic [PIX_W-1:0]   iPixSram, iPixSearch;
    logic [COORD_W-1:0] oX_sram, oY_sram, oX_search, oY_search;
    logic               oBusy, oDone;
    logic [SCORE_W-1:0] oScore;
    logic [COORD_W-1:0] s_x_sram, s_y_sram, s_x_search, s_y_search;
    logic               s_busy, s_done;
    logic [11:0]        s_score;
`ifdef CORR_SCORE_BEST_TRACK_EN
    logic               clrb;
    logic [SCORE_W-1:0] oBestScore;
    logic [COORD_W-1:0] oBestX, oBestY;
    logic [11:0]        s_best;
    logic [COORD_W-1:0] s_bx, s_by;
`endif

    int checks = 0;
    int errors = 0;
    int mode, cs, cq;
    logic [COORD_W-1:0] sx1, sx2, sy1, sy2, qx1, qx2, qy1, qy2;

    typedef struct {
        int xs; int ys; int mode; int cs; int cq; int exp;
        bit mid; bit b2b; bit clr;
    } rec_t;
    rec_t tbl[7];

    always #10 clk = ~clk;

    corr_score_engine #(.PIX_W(PIX_W), .COORD_W(COORD_W), .WIN_H(WIN_H), .WIN_V(WIN_V),
                        .RD_LAT(RD_LAT), .SCORE_W(SCORE_W)) u_dut (
        .iCLK(clk), .iRST(iRST), .iStart(iStart), .iXstart(iXstart), .iYstart(iYstart),
        .iPixSram(iPixSram), .iPixSearch(iPixSearch),
        .oX_sram(oX_sram), .oY_sram(oY_sram), .oX_search(oX_search), .oY_search(oY_search),
        .oBusy(oBusy), .oDone(oDone), .oScore(oScore)
`ifdef CORR_SCORE_BEST_TRACK_EN
        , .iClearBest(clrb), .oBestScore(oBestScore), .oBestX(oBestX), .oBestY(oBestY)
`endif
    );

    corr_score_engine #(.PIX_W(PIX_W), .COORD_W(COORD_W), .WIN_H(WIN_H), .WIN_V(WIN_V),
                        .RD_LAT(RD_LAT), .SCORE_W(12)) u_sat (
        .iCLK(clk), .iRST(iRST), .iStart(iStart), .iXstart(iXstart), .iYstart(iYstart),
        .iPixSram(iPixSram), .iPixSearch(iPixSearch),
        .oX_sram(s_x_sram), .oY_sram(s_y_sram), .oX_search(s_x_search), .oY_search(s_y_search),
        .oBusy(s_busy), .oDone(s_done), .oScore(s_score)
`ifdef CORR_SCORE_BEST_TRACK_EN
        , .iClearBest(clrb), .oBestScore(s_best), .oBestX(s_bx), .oBestY(s_by)
`endif
    );

    function automatic logic [9:0] pf_s(input int x, input int y);
        return 10'((x * 37 + y * 11) % 1024);
    endfunction

    function automatic logic [9:0] pf_q(input int x, input int y);
        return 10'((x * 5 + y * 100 + 200) % 1024);
    endfunction

    function automatic int model_score(input int xs, input int ys);
        int s = 0;
        for (int y = 0; y < WIN_V; y++)
            for (int x = 0; x < WIN_H; x++) begin
                int d;
                d = int'(pf_s((xs + x) % 8192, (ys + y) % 8192)) - int'(pf_q(x, y));
                if (d < 0) d = -d;
                s += 1023 - d;
            end
        return s;
    endfunction

    // Memory model: address seen in cycle k returns data in cycle k+RD_LAT.
    always @(posedge clk) begin
        sx1 <= oX_sram;   sx2 <= sx1;  sy1 <= oY_sram;   sy2 <= sy1;
        qx1 <= oX_search; qx2 <= qx1;  qy1 <= oY_search; qy2 <= qy1;
    end

    always_comb begin
        if (mode == 0) begin
            iPixSram   = 10'(cs);
            iPixSearch = 10'(cq);
        end else begin
            iPixSram   = pf_s(int'(sx2), int'(sy2));
            iPixSearch = pf_q(int'(qx2), int'(qy2));
        end
    end

    task automatic chk(input string nm, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_job(input rec_t r);
        int done_cnt, done_k, got2;
        bit busy_bad, addr_bad;
        longint sc, sc_sat, sc2;
        done_cnt = 0; done_k = 0; busy_bad = 0; addr_bad = 0; sc = -1; sc_sat = -1; sc2 = -1; got2 = 0;
        mode = r.mode; cs = r.cs; cq = r.cq;
        @(negedge clk);
        iXstart = COORD_W'(r.xs); iYstart = COORD_W'(r.ys); iStart = 1'b1;
        step();
        iStart = 1'b0;
        for (int k = 1; k <= 14; k++) begin
            if (oBusy !== ((k <= 10) || (r.b2b && k >= 13))) busy_bad = 1;
            if (oDone === 1'b1) begin done_cnt++; done_k = k; end
            if (k == 11) begin sc = oScore; sc_sat = s_score; end
            if (k <= 8 || k == 11 || k == 12) begin
                int ox, oy;
                ox = (k <= 8) ? (k - 1) % WIN_H : 0;
                oy = (k <= 8) ? (k - 1) / WIN_H : 0;
                if (oX_sram !== COORD_W'(r.xs + ox) || oY_sram !== COORD_W'(r.ys + oy) ||
                    oX_search !== COORD_W'(ox) || oY_search !== COORD_W'(oy)) begin
                    if (!addr_bad) $display("FAIL addr_seq: cycle %0d got sram (%0d,%0d) search (%0d,%0d) expected offset (%0d,%0d) from (%0d,%0d)",
                                            k, oX_sram, oY_sram, oX_search, oY_search, ox, oy, r.xs, r.ys);
                    addr_bad = 1;
                end
            end
            if (r.mid && k == 3) begin
                iStart = 1'b1; iXstart = COORD_W'(r.xs + 100); iYstart = COORD_W'(r.ys + 100);
            end
            if (r.mid && k == 4) begin
                iStart = 1'b0; iXstart = COORD_W'(r.xs); iYstart = COORD_W'(r.ys);
            end
            if (r.b2b && k == 11) iStart = 1'b1;
            if (r.b2b && k == 13) iStart = 1'b0;
`ifdef CORR_SCORE_BEST_TRACK_EN
            if (r.clr && k == 11) clrb = 1'b1;
            if (r.clr && k == 12) begin
                clrb = 1'b0;
                chk("best_cleared", oBestScore, 0);
            end
`endif
            step();
        end
        chk("busy_shape", busy_bad, 0);
        if (addr_bad) begin checks++; errors++; end else checks++;
        chk("done_cnt_pos", done_cnt * 100 + done_k, 111);
        chk("score", sc, r.exp);
        chk("score_sat12", sc_sat, (r.exp > 4095) ? 4095 : r.exp);
        if (r.b2b) begin
            for (int j = 0; j < 20 && got2 == 0; j++) begin
                if (oDone === 1'b1) begin got2 = 1; sc2 = oScore; end
                else step();
            end
            chk("b2b_second_done", got2, 1);
            chk("b2b_second_score", sc2, r.exp);
            step();
        end
    endtask

    initial begin
        rec_t rr;
        int got;
        iRST = 1'b1; iStart = 1'b0; iXstart = '0; iYstart = '0;
        mode = 0; cs = 0; cq = 0;
`ifdef CORR_SCORE_BEST_TRACK_EN
        clrb = 1'b0;
`endif
        tbl[0] = '{10,   20,   0, 300,  300, 8184, 0, 0, 0};
        tbl[1] = '{0,    0,    0, 600,  500, 7384, 0, 0, 0};
        tbl[2] = '{0,    0,    0, 500,  600, 7384, 0, 0, 0};
        tbl[3] = '{8190, 5,    0, 1023, 0,    0,    0, 0, 0};
        tbl[4] = '{50,   60,   0, 7,    7,    8184, 1, 0, 0};
        tbl[5] = '{8191, 8191, 0, 1,    0,    8176, 0, 1, 0};
        tbl[6] = '{3,    9,    1, 0,    0,    model_score(3, 9), 0, 0, 0};

        repeat (3) step();
        chk("rst_busy", oBusy, 0);
        chk("rst_done", oDone, 0);
        chk("rst_score", oScore, 0);
        chk("rst_x_sram", oX_sram, 0);
        chk("rst_y_search", oY_search, 0);
        iRST = 1'b0;
        step();

        for (int i = 0; i < 7; i++) run_job(tbl[i]);

        // Reset in the middle of a scan must abandon the run completely.
        @(negedge clk);
        mode = 0; cs = 300; cq = 300; iXstart = 77; iYstart = 88; iStart = 1'b1;
        step();
        iStart = 1'b0;
        repeat (3) step();
        iRST = 1'b1;
        step();
        iRST = 1'b0;
        chk("midrst_busy", oBusy, 0);
        chk("midrst_done", oDone, 0);
        chk("midrst_score", oScore, 0);
        chk("midrst_x_sram", oX_sram, 0);
        chk("midrst_y_sram", oY_sram, 0);
        got = 0;
        repeat (15) begin
            step();
            if (oDone === 1'b1) got = 1;
        end
        chk("midrst_no_stale_done", got, 0);
        rr = '{40, 41, 0, 512, 512, 8184, 0, 0, 0};
        run_job(rr);

`ifdef CORR_SCORE_BEST_TRACK_EN
        iRST = 1'b1; step(); iRST = 1'b0;
        chk("best_rst", oBestScore, 0);
        rr = '{100, 200, 0, 600, 500, 7384, 0, 0, 0};
        run_job(rr);
        chk("best_run1", oBestScore, 7384);
        rr = '{300, 400, 0, 300, 300, 8184, 0, 0, 0};
        run_job(rr);
        chk("best_run2", oBestScore, 8184);
        chk("best_x2", oBestX, 300);
        chk("best_y2", oBestY, 400);
        rr = '{500, 600, 0, 300, 300, 8184, 0, 0, 1};
        run_job(rr);
        chk("best_after_clr", oBestScore, 0);
        chk("best_x_after_clr", oBestX, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got no end of test, expected completion");
        $fatal(1, "timeout");
    end

endmodule
